// File: rtl/fetch_unit_if.sv
// fetch_unit_if: IMEM request/response, redirect and decode handshake bundle of the fetch unit.
interface fetch_unit_if #(
    parameter int CPU_ADDR_BITS = 32,
    parameter int CPU_INST_BITS = 32,
    parameter int FETCH_WIDTH   = 2
);
    logic                                 imem_req_rdy;
    logic                                 imem_req_val;
    logic [CPU_ADDR_BITS-1:0]             imem_req_packet;
    logic                                 imem_rec_rdy;
    logic                                 imem_rec_val;
    logic [FETCH_WIDTH*CPU_INST_BITS-1:0] imem_rec_packet;
    logic                                 redirect_val;
    logic [CPU_ADDR_BITS-1:0]             redirect_pc;
    logic                                 dec_val;
    logic                                 dec_rdy;
    logic [CPU_ADDR_BITS-1:0]             dec_pc;
    logic [FETCH_WIDTH*CPU_INST_BITS-1:0] dec_insts;
    modport master (
        input  imem_req_rdy, imem_rec_val, imem_rec_packet, redirect_val, redirect_pc, dec_rdy,
        output imem_req_val, imem_req_packet, imem_rec_rdy, dec_val, dec_pc, dec_insts
    );
    modport slave (
        output imem_req_rdy, imem_rec_val, imem_rec_packet, redirect_val, redirect_pc, dec_rdy,
        input  imem_req_val, imem_req_packet, imem_rec_rdy, dec_val, dec_pc, dec_insts
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing one bundle fetch per cycle into a small buffer feeding decode.
module fetch_unit #(
    parameter int                       CPU_ADDR_BITS = 32,
    parameter int                       CPU_INST_BITS = 32,
    parameter int                       FETCH_WIDTH   = 2,
    parameter int unsigned              FBUF_DEPTH    = 4,
    parameter logic [CPU_ADDR_BITS-1:0] RESET_PC      = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.master f
);
    localparam int CW = $clog2(FBUF_DEPTH + 1);
    localparam int PW = $clog2(FBUF_DEPTH);
    localparam int BW = FETCH_WIDTH * CPU_INST_BITS;

    logic [CPU_ADDR_BITS-1:0] pc, req_pc_q;
    logic                     pending;
    logic [CW-1:0]            count;
    logic [PW-1:0]            head, tail;
    logic [CPU_ADDR_BITS-1:0] fb_pc    [FBUF_DEPTH];
    logic [BW-1:0]            fb_insts [FBUF_DEPTH];
    logic                     credit, req_fire, enq, deq;
    logic                     unused;

    // Counting the in-flight request reserves a buffer slot for its response.
    assign credit            = (32'(count) + 32'(pending)) < FBUF_DEPTH;
    assign f.imem_req_val    = !rst && !f.redirect_val && credit;
    assign f.imem_rec_rdy    = !rst && credit;
    assign f.imem_req_packet = pc;
    assign req_fire          = f.imem_req_val && f.imem_req_rdy;
    assign enq               = pending && f.imem_rec_val;
    assign f.dec_val         = (count != '0) && !f.redirect_val;
    assign deq               = f.dec_val && f.dec_rdy;
    assign f.dec_pc          = fb_pc[head];
    assign f.dec_insts       = fb_insts[head];
    assign unused            = ^f.redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc_q <= '0;
            pending  <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            for (int i = 0; i < int'(FBUF_DEPTH); i++) begin
                fb_pc[i]    <= '0;
                fb_insts[i] <= '0;
            end
        end else if (f.redirect_val) begin
            pc      <= {f.redirect_pc[CPU_ADDR_BITS-1:2], 2'b00};
            pending <= 1'b0;
            count   <= '0;
            head    <= '0;
            tail    <= '0;
        end else begin
            pending <= req_fire;
            if (req_fire) begin
                pc       <= pc + CPU_ADDR_BITS'(4 * FETCH_WIDTH);
                req_pc_q <= pc;
            end
            if (enq) begin
                fb_pc[tail]    <= req_pc_q;
                fb_insts[tail] <= f.imem_rec_packet;
                tail           <= tail + PW'(1);
            end
            if (deq)
                head <= head + PW'(1);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        (enq && !f.redirect_val) |-> (32'(count) < FBUF_DEPTH));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch ordering, buffering, redirect, stall, wrap and reset.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    fetch_unit_if f ();
    fetch_unit dut (.clk(clk), .rst(rst), .f(f));

    always #5 clk = ~clk;

    function automatic logic [31:0] inst(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dec_chk(input string tag, input logic [31:0] a);
        chk({tag, " dec_val"}, 64'(f.dec_val), 64'd1);
        chk({tag, " dec_pc"}, 64'(f.dec_pc), 64'(a));
        chk({tag, " dec_insts"}, f.dec_insts, {inst(a + 32'd4), inst(a)});
    endtask

    // Memory answers one cycle after an accepted request and then holds its last response.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        fire = f.imem_req_val && f.imem_req_rdy;
        a    = f.imem_req_packet;
        @(posedge clk);
        #1;
        if (fire) begin
            f.imem_rec_val    = 1'b1;
            f.imem_rec_packet = {inst(a + 32'd4), inst(a)};
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        f.imem_rec_val = 1'b0;
        f.redirect_val = 1'b0;
        f.imem_req_rdy = 1'b1;
        f.dec_rdy      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, " req_val"}, 64'(f.imem_req_val), 64'd0);
        chk({tag, " rec_rdy"}, 64'(f.imem_rec_rdy), 64'd0);
        chk({tag, " req_packet"}, 64'(f.imem_req_packet), 64'd0);
        chk({tag, " dec_val"}, 64'(f.dec_val), 64'd0);
        chk({tag, " dec_pc"}, 64'(f.dec_pc), 64'd0);
        chk({tag, " dec_insts"}, f.dec_insts, 64'd0);
    endtask

    initial begin
        f.imem_req_rdy    = 1'b1;
        f.imem_rec_val    = 1'b0;
        f.imem_rec_packet = '0;
        f.redirect_val    = 1'b0;
        f.redirect_pc     = '0;
        f.dec_rdy         = 1'b0;
        #1 rst = 1'b1;
        #1 reset_chk("reset");

        // streaming with decode always ready
        do_reset();
        f.dec_rdy = 1'b1;
        #1;
        chk("c0 req_val", 64'(f.imem_req_val), 64'd1);
        chk("c0 req_packet", 64'(f.imem_req_packet), 64'd0);
        chk("c0 dec_val", 64'(f.dec_val), 64'd0);
        tick();
        #1;
        chk("c1 dec_val", 64'(f.dec_val), 64'd0);
        chk("c1 req_packet", 64'(f.imem_req_packet), 64'd8);
        tick();
        for (int k = 0; k < 6; k++) begin
            #1 dec_chk("stream", 32'(k * 8));
            tick();
        end

        // decode stalled: buffer fills to depth, then drains in order
        do_reset();
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c == 5) begin
                dec_chk("full head", 32'h0);
                chk("full req_val", 64'(f.imem_req_val), 64'd0);
            end
            if (c == 9)
                chk("full req_val c9", 64'(f.imem_req_val), 64'd0);
            tick();
        end
        f.dec_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1 dec_chk("drain", 32'(k * 8));
            if (k == 0)
                chk("drain req_val", 64'(f.imem_req_val), 64'd0);
            if (k == 1) begin
                chk("resume req_val", 64'(f.imem_req_val), 64'd1);
                chk("resume req_packet", 64'(f.imem_req_packet), 64'h20);
            end
            tick();
        end

        // redirect with a request pending and two bundles buffered
        do_reset();
        repeat (3) begin
            #1 tick();
        end
        f.redirect_val = 1'b1;
        f.redirect_pc  = 32'h103;
        #1;
        chk("redir dec_val", 64'(f.dec_val), 64'd0);
        chk("redir req_val", 64'(f.imem_req_val), 64'd0);
        tick();
        f.redirect_val = 1'b0;
        #1;
        chk("redir+1 dec_val", 64'(f.dec_val), 64'd0);
        chk("redir+1 req_val", 64'(f.imem_req_val), 64'd1);
        chk("redir+1 req_packet", 64'(f.imem_req_packet), 64'h100);
        tick();
        #1 chk("redir+2 dec_val", 64'(f.dec_val), 64'd0);
        tick();
        #1 dec_chk("redir+3", 32'h100);

        // redirect colliding with a decode handshake on a full buffer
        do_reset();
        repeat (5) begin
            #1 tick();
        end
        f.dec_rdy      = 1'b1;
        f.redirect_val = 1'b1;
        f.redirect_pc  = 32'h40;
        #1;
        chk("flush dec_val", 64'(f.dec_val), 64'd0);
        chk("flush req_val", 64'(f.imem_req_val), 64'd0);
        tick();
        f.redirect_val = 1'b0;
        #1;
        chk("flush+1 dec_val", 64'(f.dec_val), 64'd0);
        chk("flush+1 req_packet", 64'(f.imem_req_packet), 64'h40);
        tick();
        #1 tick();
        #1 dec_chk("flush+3", 32'h40);

        // memory not ready for one cycle
        do_reset();
        f.dec_rdy = 1'b1;
        #1 tick();
        f.imem_req_rdy = 1'b0;
        #1 chk("stall req_packet", 64'(f.imem_req_packet), 64'h8);
        tick();
        f.imem_req_rdy = 1'b1;
        #1;
        chk("retry req_packet", 64'(f.imem_req_packet), 64'h8);
        chk("retry req_val", 64'(f.imem_req_val), 64'd1);
        dec_chk("retry", 32'h0);
        tick();
        #1 chk("bubble dec_val", 64'(f.dec_val), 64'd0);
        tick();
        #1 dec_chk("after stall", 32'h8);
        tick();
        #1 dec_chk("after stall+1", 32'h10);

        // PC wrap, then reset mid-stream
        do_reset();
        f.dec_rdy      = 1'b1;
        f.redirect_val = 1'b1;
        f.redirect_pc  = 32'hFFFF_FFF8;
        #1 tick();
        f.redirect_val = 1'b0;
        #1 chk("wrap req_packet", 64'(f.imem_req_packet), 64'hFFFF_FFF8);
        tick();
        #1 chk("wrapped req_packet", 64'(f.imem_req_packet), 64'h0);
        tick();
        #1 dec_chk("wrap top", 32'hFFFF_FFF8);
        tick();
        #1 dec_chk("wrap zero", 32'h0);
        rst = 1'b1;
        #1 reset_chk("mid reset");
        do_reset();
        f.dec_rdy = 1'b1;
        #1;
        chk("restart req_packet", 64'(f.imem_req_packet), 64'h0);
        chk("restart req_val", 64'(f.imem_req_val), 64'd1);
        tick();
        #1 tick();
        #1 dec_chk("restart", 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
